tex_scan_loader: RTL and testbench
==================================

Name: tex_scan_loader

Overview:
- On-chip sequencer that drives the texture-memory scan chain.
- Accepts texture (address, byte) writes over a valid/ready interface, serialises each write, and generates the chain pins: data, non-overlapping phi1/phi2 shift clocks, and a latch strobe.
- Sits between the host-side loader (or the UART config path) and the texture scan chain. It replaces bit-banged pin sequencing.

Parameters:
- ADDR_W, 11: texture address width (2048 bytes).
- DATA_W, 8: texture byte width.
- PHASE_CYC, 1: clk cycles each of phi1 and phi2 is held high (must be ≥1).
- CNT_W, 16: width of the completed-word counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  write request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  texture address
- req_data  in  DATA_W  texture byte
- abort  in  1  synchronous cancel of the in-flight word
- scan_data  out  1  serial data to chain
- scan_phi1  out  1  shift phase 1
- scan_phi2  out  1  shift phase 2
- scan_latch  out  1  parallel-load strobe
- busy  out  1  word in flight
- word_cnt  out  CNT_W  number of words latched, wraps

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - req_ready=1.
  - busy, scan_data, scan_phi1, scan_phi2 and scan_latch all 0.
  - word_cnt=0.
  - All outputs are registered.
- Frame format:
  - NBITS = 1+ADDR_W+DATA_W (20 at defaults).
  - Bit order: start bit 0, then address MSB-first, then data MSB-first.
- Accept:
  - A request is accepted when req_valid && req_ready in IDLE.
  - On accept, shift register <= {1'b0, req_addr, req_data}, bit counter <= NBITS-1, and the state moves to SETUP.
  - req_ready=0 and busy=1 from the cycle after accept until the word ends.
- States:
  - IDLE: waits for accept.
  - SETUP: 1 cycle. scan_data <= current MSB; both phis 0.
  - PHI1: PHASE_CYC cycles with scan_phi1=1.
  - PHI2: PHASE_CYC cycles with scan_phi2=1. At the end, shift left. If the bit counter is 0, go to LATCH; otherwise decrement and go to SETUP.
  - LATCH: 1 cycle with scan_latch=1 and scan_data=0; word_cnt increments (mod 2^CNT_W). Next state IDLE, and req_ready=1 on the following cycle.
- Invariants:
  - scan_phi1 and scan_phi2 are never 1 in the same cycle.
  - scan_data changes only on SETUP entry or LATCH/IDLE entry, never while a phi is high.
  - scan_latch never coincides with a phi.
- Timing (accept at cycle T):
  - First SETUP at T+1.
  - First phi1 at T+2.
  - LATCH at T+1+NBITS*(1+2*PHASE_CYC), i.e. T+61 at defaults.
  - req_ready at T+62.
- Throughput: back-to-back period is NBITS*(1+2*PHASE_CYC)+2 cycles (62 at defaults).
- abort:
  - Has priority over all state transitions.
  - When sampled 1 in any non-IDLE state, the next cycle is IDLE with every pin output 0, no latch, word_cnt unchanged, and req_ready=1.
  - In IDLE, abort suppresses acceptance that cycle.
- Reset mid-word: rst_n low immediately forces the reset values; no latch is issued.
- req_addr/req_data are sampled only at accept; later changes have no effect.

Test Plan:
- Single write, addr=0x7FF, data=0xA5:
  - Accept at T.
  - scan_data at each phi1 pulse = 0,1×11,1,0,1,0,0,1,0,1.
  - 20 phi1 and 20 phi2 pulses.
  - scan_latch=1 only at T+61; word_cnt=1; req_ready=1 at T+62.
- Three words with req_valid held high:
  - Latches at T+61, T+123, T+185.
  - Each word's bits match its own addr/data.
  - word_cnt=3.
- abort asserted during PHI1 of bit 5:
  - Next cycle all pins are 0 and req_ready=1.
  - No latch; word_cnt unchanged.
  - A following write of addr=0x001, data=0xFF completes normally.
- rst_n pulsed low during PHI2 of bit 12:
  - Outputs reset asynchronously, no latch, word_cnt=0.
  - Re-accept works after release.
- PHASE_CYC=3:
  - Each phi is high exactly 3 cycles, with 1 low cycle between phi2 and the next phi1.
  - LATCH at T+141.
  - Phase non-overlap checked every cycle by assertion.
- CNT_W=2, five writes: word_cnt sequence after each latch is 1,2,3,0,1.

Source files
------------

// File: rtl/tex_scan_loader.sv
// tex_scan_loader: serialises (address, byte) texture writes onto the texture
// scan chain as a start bit, address MSB-first and data MSB-first. Each bit is
// presented in a one-cycle setup slot, shifted by non-overlapping phi1/phi2
// pulses, and the word is closed with a one-cycle parallel-load latch strobe.
module tex_scan_loader #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PHASE_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              abort,
    output logic              scan_data,
    output logic              scan_phi1,
    output logic              scan_phi2,
    output logic              scan_latch,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned NBITS = 1 + ADDR_W + DATA_W;
    localparam int unsigned BIT_W = $clog2(NBITS);
    localparam int unsigned PH_W  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PHI1  = 3'd2,
        S_PHI2  = 3'd3,
        S_LATCH = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [NBITS-1:0]  sreg_q, sreg_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [PH_W-1:0]   ph_q, ph_d;

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              data_q, data_d;
    logic              phi1_q, phi1_d;
    logic              phi2_q, phi2_d;
    logic              latch_q, latch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept_c;
    logic              phase_end_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
        end
    end

    // Next state: accept, per-bit setup/phi1/phi2 sequencing, latch; abort wins.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_d       = bit_q;
        ph_d        = ph_q;
        accept_c    = (state_q == S_IDLE) && req_valid && ready_q && !abort;
        phase_end_c = (ph_q == PH_W'(PHASE_CYC - 1));

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ph_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        sreg_d  = {1'b0, req_addr, req_data};
                        bit_d   = BIT_W'(NBITS - 1);
                        ph_d    = '0;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    ph_d    = '0;
                    state_d = S_PHI1;
                end
                S_PHI1: begin
                    if (phase_end_c) begin
                        ph_d    = '0;
                        state_d = S_PHI2;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_PHI2: begin
                    if (phase_end_c) begin
                        ph_d   = '0;
                        sreg_d = sreg_q << 1;
                        if (bit_q == '0) begin
                            state_d = S_LATCH;
                        end else begin
                            bit_d   = bit_q - BIT_W'(1);
                            state_d = S_SETUP;
                        end
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_LATCH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Pin values for the state being entered; data only moves on setup/latch/idle entry.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        phi1_d  = (state_d == S_PHI1);
        phi2_d  = (state_d == S_PHI2);
        latch_d = (state_d == S_LATCH);
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (state_d == S_SETUP) begin
            data_d = sreg_d[NBITS-1];
        end else if ((state_d == S_LATCH) || (state_d == S_IDLE)) begin
            data_d = 1'b0;
        end
        if (state_d == S_LATCH) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= 1'b0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            latch_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign scan_data  = data_q;
    assign scan_phi1  = phi1_q;
    assign scan_phi2  = phi2_q;
    assign scan_latch = latch_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_tex_scan_loader.sv
// Bench for tex_scan_loader: two instances (default timing, and PHASE_CYC=3 with
// a 2-bit counter) checked every cycle against a position-in-word model, plus
// hand-computed expectations for the directed scenarios.
module tb_tex_scan_loader;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int NB  = 1 + AW + DW;
    localparam int PH0 = 1;
    localparam int PH1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid [2];
    logic          abort_i   [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_data  [2];
    logic          req_ready [2];
    logic          busy      [2];
    logic          scan_data [2];
    logic          scan_phi1 [2];
    logic          scan_phi2 [2];
    logic          scan_latch[2];
    logic [15:0]   wc0;
    logic [1:0]    wc1;

    tex_scan_loader #(.ADDR_W(AW), .DATA_W(DW), .PHASE_CYC(PH0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .abort(abort_i[0]),
        .scan_data(scan_data[0]), .scan_phi1(scan_phi1[0]), .scan_phi2(scan_phi2[0]),
        .scan_latch(scan_latch[0]), .busy(busy[0]), .word_cnt(wc0)
    );

    tex_scan_loader #(.ADDR_W(AW), .DATA_W(DW), .PHASE_CYC(PH1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]), .abort(abort_i[1]),
        .scan_data(scan_data[1]), .scan_phi1(scan_phi1[1]), .scan_phi2(scan_phi2[1]),
        .scan_latch(scan_latch[1]), .busy(busy[1]), .word_cnt(wc1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // pos = cycle index inside the current word (-1 when idle).
    int            pos  [2] = '{-1, -1};
    int            mcnt [2] = '{0, 0};
    logic [NB-1:0] frame[2];

    function automatic int ph_of(int k);
        return (k == 0) ? PH0 : PH1;
    endfunction

    function automatic int word_len(int k);
        return NB * (1 + 2 * ph_of(k)) + 1;
    endfunction

    function automatic int cmask(int k);
        return (k == 0) ? 32'hFFFF : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                pos[k]  <= -1;
                mcnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int p;
                p = pos[k];
                if (p >= 0) begin
                    if (abort_i[k]) begin
                        p = -1;
                    end else begin
                        p = p + 1;
                        if (p == word_len(k)) p = -1;
                        else if (p == word_len(k) - 1) mcnt[k] <= (mcnt[k] + 1) & cmask(k);
                    end
                end else if (req_valid[k] && !abort_i[k]) begin
                    frame[k] <= {1'b0, req_addr[k], req_data[k]};
                    p = 0;
                end
                pos[k] <= p;
            end
        end
    end

    // {ready, busy, data, phi1, phi2, latch} required for the current cycle.
    function automatic logic [5:0] exp_vec(int k);
        int p, ph, bl, b, s;
        p  = pos[k];
        ph = ph_of(k);
        bl = 1 + 2 * ph;
        if (p < 0) return 6'b100000;
        if (p == word_len(k) - 1) return 6'b010001;
        b = p / bl;
        s = p % bl;
        return {1'b0, 1'b1, frame[k][NB-1-b], (s >= 1) && (s <= ph), (s > ph), 1'b0};
    endfunction

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] wc_of(int k);
        return (k == 0) ? 32'(wc0) : 32'(wc1);
    endfunction

    // Logs of observed pins, used by the directed literal checks.
    int            lat_cyc [2][64];
    logic [NB-1:0] lat_word[2][64];
    int            lat_cnt [2][64];
    int            nlat [2] = '{0, 0};
    int            np1  [2] = '{0, 0};
    int            np2  [2] = '{0, 0};
    int            run1 [2] = '{0, 0};
    int            run2 [2] = '{0, 0};
    logic          pv1  [2] = '{1'b0, 1'b0};
    logic          pv2  [2] = '{1'b0, 1'b0};
    logic [NB-1:0] bits [2];

    // One cycle: advance to the falling edge, compare every pin, update logs.
    task automatic tick();
        logic [5:0] v;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            v = exp_vec(k);
            check("req_ready",  k, 32'(req_ready[k]),  32'(v[5]));
            check("busy",       k, 32'(busy[k]),       32'(v[4]));
            check("scan_data",  k, 32'(scan_data[k]),  32'(v[3]));
            check("scan_phi1",  k, 32'(scan_phi1[k]),  32'(v[2]));
            check("scan_phi2",  k, 32'(scan_phi2[k]),  32'(v[1]));
            check("scan_latch", k, 32'(scan_latch[k]), 32'(v[0]));
            check("word_cnt",   k, wc_of(k), 32'(mcnt[k]));
            check("phi_overlap",   k, 32'(scan_phi1[k] & scan_phi2[k]), 32'd0);
            check("latch_overlap", k, 32'(scan_latch[k] & (scan_phi1[k] | scan_phi2[k])), 32'd0);

            if (scan_phi1[k] && !pv1[k]) begin
                bits[k] = {bits[k][NB-2:0], scan_data[k]};
                np1[k]++;
            end
            if (scan_phi2[k] && !pv2[k]) np2[k]++;
            if (scan_phi1[k]) run1[k]++;
            else begin
                if (pv1[k] && busy[k]) check("phi1_width", k, 32'(run1[k]), 32'(ph_of(k)));
                run1[k] = 0;
            end
            if (scan_phi2[k]) run2[k]++;
            else begin
                if (pv2[k] && busy[k]) check("phi2_width", k, 32'(run2[k]), 32'(ph_of(k)));
                run2[k] = 0;
            end
            if (scan_latch[k]) begin
                lat_cyc[k][nlat[k] % 64]  = cyc;
                lat_word[k][nlat[k] % 64] = bits[k];
                lat_cnt[k][nlat[k] % 64]  = int'(wc_of(k));
                nlat[k]++;
            end
            pv1[k] = scan_phi1[k];
            pv2[k] = scan_phi2[k];
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // Present one write and return the cycle in which it is accepted.
    task automatic send(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
        int g;
        g = 0;
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_data[k]  = d;
        while (!req_ready[k] && g < 300) begin
            tick();
            g++;
        end
        check("ready_wait", k, 32'(req_ready[k]), 32'd1);
        t = cyc;
        tick();
        req_valid[k] = 1'b0;
        req_addr[k]  = AW'($urandom);
        req_data[k]  = DW'($urandom);
    endtask

    int            t, base, b1, b2, g;
    int            ta[5];
    logic [AW-1:0] wa[5];
    logic [DW-1:0] wd[5];
    int            cexp[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            abort_i[k]   = 1'b0;
            req_addr[k]  = '0;
            req_data[k]  = '0;
            bits[k]      = '0;
        end
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", 0, 32'(req_ready[0]), 32'd1);
        check("rst_busy",  0, 32'(busy[0]), 32'd0);
        check("rst_cnt",   0, 32'(wc0), 32'd0);

        // Single write 0x7FF / 0xA5.
        base = nlat[0]; b1 = np1[0]; b2 = np2[0];
        send(0, 11'h7FF, 8'hA5, t);
        wait_cyc(t + 62);
        check("t1_bits",      0, 32'(lat_word[0][base % 64]), 32'h7FFA5);
        check("t1_phi1_n",    0, 32'(np1[0] - b1), 32'd20);
        check("t1_phi2_n",    0, 32'(np2[0] - b2), 32'd20);
        check("t1_latch_n",   0, 32'(nlat[0] - base), 32'd1);
        check("t1_latch_cyc", 0, 32'(lat_cyc[0][base % 64]), 32'(t + 61));
        check("t1_cnt",       0, 32'(wc0), 32'd1);
        check("t1_ready",     0, 32'(req_ready[0]), 32'd1);

        // Three words with req_valid held high.
        base = nlat[0];
        for (int i = 0; i < 3; i++) begin
            wa[i] = AW'($urandom);
            wd[i] = DW'($urandom);
        end
        req_valid[0] = 1'b1;
        req_addr[0]  = wa[0];
        req_data[0]  = wd[0];
        for (int i = 0; i < 3; i++) begin
            g = 0;
            while (!req_ready[0] && g < 300) begin
                tick();
                g++;
            end
            check("t2_ready_wait", 0, 32'(req_ready[0]), 32'd1);
            ta[i] = cyc;
            tick();
            if (i < 2) begin
                req_addr[0] = wa[i+1];
                req_data[0] = wd[i+1];
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        wait_cyc(ta[0] + 186);
        for (int i = 0; i < 3; i++) begin
            check("t2_latch_cyc", 0, 32'(lat_cyc[0][(base + i) % 64]), 32'(ta[0] + 61 + 62 * i));
            check("t2_word", 0, 32'(lat_word[0][(base + i) % 64]), 32'({1'b0, wa[i], wd[i]}));
        end
        check("t2_cnt", 0, 32'(wc0), 32'd4);

        // Abort during phi1 of bit 5, then a clean write.
        base = nlat[0];
        send(0, AW'($urandom), DW'($urandom), t);
        wait_cyc(t + 17);
        check("t3_in_phi1", 0, 32'(scan_phi1[0]), 32'd1);
        abort_i[0] = 1'b1;
        tick();
        abort_i[0] = 1'b0;
        check("t3_pins", 0, 32'({scan_data[0], scan_phi1[0], scan_phi2[0], scan_latch[0], busy[0]}), 32'd0);
        check("t3_ready", 0, 32'(req_ready[0]), 32'd1);
        wait_cyc(t + 70);
        check("t3_no_latch", 0, 32'(nlat[0] - base), 32'd0);
        check("t3_cnt", 0, 32'(wc0), 32'd4);
        send(0, 11'h001, 8'hFF, t);
        wait_cyc(t + 62);
        check("t3_word", 0, 32'(lat_word[0][base % 64]), 32'h001FF);
        check("t3_latch_cyc", 0, 32'(lat_cyc[0][base % 64]), 32'(t + 61));
        check("t3_cnt2", 0, 32'(wc0), 32'd5);

        // Reset pulse during phi2 of bit 12.
        base = nlat[0];
        send(0, AW'($urandom), DW'($urandom), t);
        wait_cyc(t + 39);
        check("t4_in_phi2", 0, 32'(scan_phi2[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t4_pins", 0, 32'({scan_data[0], scan_phi1[0], scan_phi2[0], scan_latch[0], busy[0]}), 32'd0);
        check("t4_ready", 0, 32'(req_ready[0]), 32'd1);
        check("t4_cnt", 0, 32'(wc0), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t4_no_latch", 0, 32'(nlat[0] - base), 32'd0);
        send(0, AW'($urandom), DW'($urandom), t);
        wait_cyc(t + 62);
        check("t4_latch_cyc", 0, 32'(lat_cyc[0][base % 64]), 32'(t + 61));
        check("t4_cnt", 0, 32'(wc0), 32'd1);

        // PHASE_CYC=3, 2-bit counter: five writes.
        base = nlat[1];
        for (int i = 0; i < 5; i++) begin
            wa[i] = AW'($urandom);
            wd[i] = DW'($urandom);
            send(1, wa[i], wd[i], ta[i]);
            wait_cyc(ta[i] + 142);
            check("t5_latch_cyc", 1, 32'(lat_cyc[1][(base + i) % 64]), 32'(ta[i] + 141));
            check("t5_word", 1, 32'(lat_word[1][(base + i) % 64]), 32'({1'b0, wa[i], wd[i]}));
            check("t5_cnt", 1, 32'(lat_cnt[1][(base + i) % 64]), 32'(cexp[i]));
        end

        // Randomised traffic with occasional aborts on both instances.
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = ($urandom % 4) != 0;
                req_addr[k]  = AW'($urandom);
                req_data[k]  = DW'($urandom);
                abort_i[k]   = ($urandom % 150) == 0;
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            abort_i[k]   = 1'b0;
        end
        repeat (150) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
